// File: rtl/core_config_pkg.sv
// Shared configuration for the reset sequencer: default sizing, the reset-cause
// encoding reported on the status path, and the sequencer state type.
package core_config_pkg;

  localparam int unsigned RST_STAGES      = 3;
  localparam int unsigned RST_HOLD_CYCLES = 8;
  localparam int unsigned RST_STAGE_DELAY = 4;
  localparam int unsigned RST_ACK_TIMEOUT = 64;

  typedef enum logic [1:0] {
    RST_POR = 2'b00,
    RST_SW  = 2'b01,
    RST_WDT = 2'b10,
    RST_DBG = 2'b11
  } rst_cause_t;

  typedef enum logic [1:0] {
    ASSERT,
    WAIT_ACK,
    GAP,
    RUN
  } rstseq_state_t;

  // Largest of three cycle counts; sizes the shared down-counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases per-domain resets in ascending order (stage 0 first). Each stage
// waits for its ready handshake or a timeout, then a gap before the next one.
// Software, watchdog and debug requests restart the whole sequence and record
// the winning cause; timeout flags survive restarts and clear only on rst_n.
module reset_sequencer
  import core_config_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = RST_STAGES,
  parameter int unsigned HOLD_CYCLES = RST_HOLD_CYCLES,
  parameter int unsigned STAGE_DELAY = RST_STAGE_DELAY,
  parameter int unsigned ACK_TIMEOUT = RST_ACK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst_req,
  input  logic                  wdt_rst_req,
  input  logic                  dbg_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic [1:0]            rst_cause,
  output logic [NUM_STAGES-1:0] timeout_flags
);

  localparam int unsigned CNT_MAX = max3(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT);
  localparam int unsigned CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = ($clog2(NUM_STAGES) > 0) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] ACK_LOAD   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);

  rstseq_state_t           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        idx_nxt;
  logic [NUM_STAGES-1:0]   srst_q, srst_d;
  logic                    done_q, done_d;
  rst_cause_t              cause_q, cause_d;
  logic [NUM_STAGES-1:0]   tflags_q, tflags_d;
  logic                    any_req;
  logic                    ack;

  assign any_req = sw_rst_req | wdt_rst_req | dbg_rst_req;
  assign idx_nxt = idx_q + IDX_W'(1);

  // State, counter, index and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ASSERT;
      cnt_q    <= HOLD_LOAD;
      idx_q    <= '0;
      srst_q   <= '0;
      done_q   <= 1'b0;
      cause_q  <= RST_POR;
      tflags_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      srst_q   <= srst_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
      tflags_q <= tflags_d;
    end
  end

  // Next-state: a request pre-empts every state; otherwise step the sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    srst_d   = srst_q;
    done_d   = done_q;
    cause_d  = cause_q;
    tflags_d = tflags_q;
    ack      = 1'b0;

    if (any_req) begin
      if (wdt_rst_req)      cause_d = RST_WDT;
      else if (dbg_rst_req) cause_d = RST_DBG;
      else                  cause_d = RST_SW;
      srst_d  = '0;
      done_d  = 1'b0;
      idx_d   = '0;
      cnt_d   = HOLD_LOAD;
      state_d = ASSERT;
    end else begin
      unique case (state_q)
        ASSERT: begin
          srst_d = '0;
          if (cnt_q == '0) begin
            srst_d[idx_q] = 1'b1;
            cnt_d         = ACK_LOAD;
            state_d       = WAIT_ACK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (stage_ready[idx_q]) begin
            ack = 1'b1;
          end else if (cnt_q == '0) begin
            tflags_d[idx_q] = 1'b1;
            ack             = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (ack) begin
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = RUN;
            end else begin
              cnt_d   = DELAY_LOAD;
              state_d = GAP;
            end
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            idx_d           = idx_nxt;
            srst_d[idx_nxt] = 1'b1;
            cnt_d           = ACK_LOAD;
            state_d         = WAIT_ACK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = ASSERT;
        end
      endcase
    end
  end

  assign stage_rst_n   = srst_q;
  assign seq_done      = done_q;
  assign rst_cause     = cause_q;
  assign timeout_flags = tflags_q;

endmodule
